// File: rtl/avl_dp_ram_v2_if.sv
// rtl/avl_dp_ram_v2_if.sv - Avalon-MM slave port bundle for avl_dp_ram_v2
interface avl_dp_ram_v2_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [31:0]       address;
  logic [BE_W-1:0]   byte_en;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] write_data;
  logic              request_ready;
  logic [DATA_W-1:0] read_data;
  logic              read_data_valid;
  logic              resp_err;

  modport master (
    output address, byte_en, read, write, write_data,
    input  request_ready, read_data, read_data_valid, resp_err
  );

  modport slave (
    input  address, byte_en, read, write, write_data,
    output request_ready, read_data, read_data_valid, resp_err
  );
endinterface

// File: rtl/avl_dp_ram_v2.sv
// rtl/avl_dp_ram_v2.sv - parametrised dual-port Avalon-MM on-chip RAM
module avl_dp_ram_v2 #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 65536,
  parameter int RD_LATENCY  = 1,
  parameter int WR_PRIORITY = 0,
  parameter int RDW_NEW     = 0
) (
  input logic            clk,
  input logic            rest,
  avl_dp_ram_v2_if.slave s0,
  avl_dp_ram_v2_if.slave s1
);
  localparam int BE_W = DATA_W / 8;
  localparam int LSB  = $clog2(BE_W);
  localparam int AW   = $clog2(DEPTH);
  // HI is the port that wins an overlapping byte lane; LO is written first
  localparam int HI   = (WR_PRIORITY == 1) ? 1 : 0;
  localparam int LO   = 1 - HI;

  generate
    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("avl_dp_ram_v2: DATA_W must be 32 or 64");
    end
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0 || AW + LSB > 31) begin : g_bad_depth
      $error("avl_dp_ram_v2: DEPTH must be a power of two, at least 16, addressable in 32 bits");
    end
    if (!(RD_LATENCY == 1 || RD_LATENCY == 2)) begin : g_bad_latency
      $error("avl_dp_ram_v2: RD_LATENCY must be 1 or 2");
    end
    if (!(WR_PRIORITY == 0 || WR_PRIORITY == 1)) begin : g_bad_priority
      $error("avl_dp_ram_v2: WR_PRIORITY must be 0 or 1");
    end
  endgenerate

  logic [31:0]       addr    [2];
  logic [BE_W-1:0]   be      [2];
  logic [DATA_W-1:0] wd      [2];
  logic [AW-1:0]     idx     [2];
  logic [DATA_W-1:0] rd_word [2];
  logic [1:0]        rd_req, wr_req, rd_acc, wr_acc, oor;

  logic [DATA_W-1:0] mem [DEPTH];

  assign addr[0] = s0.address;
  assign addr[1] = s1.address;
  assign be[0]   = s0.byte_en;
  assign be[1]   = s1.byte_en;
  assign wd[0]   = s0.write_data;
  assign wd[1]   = s1.write_data;
  assign rd_req  = {s1.read, s0.read};
  assign wr_req  = {s1.write, s0.write};

  assign s0.request_ready = !rest;
  assign s1.request_ready = !rest;

  // Address decode and request acceptance; out-of-range writes are dropped here
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      idx[p]    = addr[p][AW+LSB-1:LSB];
      oor[p]    = |addr[p][31:AW+LSB];
      rd_acc[p] = rd_req[p] & ~rest;
      wr_acc[p] = wr_req[p] & ~rest & ~oor[p];
    end
  end

  // Read word: pre-write contents, or the merged post-write word when the other port writes it
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[idx[p]];
      if (RDW_NEW == 1 && wr_acc[1-p] && idx[1-p] == idx[p]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_acc[LO] && idx[LO] == idx[p] && be[LO][b]) rd_word[p][8*b +: 8] = wd[LO][8*b +: 8];
          if (wr_acc[HI] && idx[HI] == idx[p] && be[HI][b]) rd_word[p][8*b +: 8] = wd[HI][8*b +: 8];
        end
      end
    end
  end

  // Byte-lane writes; the priority port is written last so it owns overlapping lanes
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_acc[LO] && be[LO][b]) mem[idx[LO]][8*b +: 8] <= wd[LO][8*b +: 8];
      if (wr_acc[HI] && be[HI][b]) mem[idx[HI]][8*b +: 8] <= wd[HI][8*b +: 8];
    end
  end

  logic [1:0]        v1, e1;
  logic [DATA_W-1:0] d1 [2];
  logic [1:0]        v_out, e_out;
  logic [DATA_W-1:0] d_out [2];

  // First read stage: data captured only on an accepted read so it holds otherwise
  always_ff @(posedge clk) begin
    if (rest) begin
      v1 <= '0;
      e1 <= '0;
      for (int p = 0; p < 2; p++) d1[p] <= '0;
    end else begin
      v1 <= rd_acc;
      e1 <= rd_acc & oor;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) d1[p] <= oor[p] ? '0 : rd_word[p];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0]        v2, e2;
      logic [DATA_W-1:0] d2 [2];

      // Optional output stage moving data, valid and err together
      always_ff @(posedge clk) begin
        if (rest) begin
          v2 <= '0;
          e2 <= '0;
          for (int p = 0; p < 2; p++) d2[p] <= '0;
        end else begin
          v2 <= v1;
          e2 <= e1;
          for (int p = 0; p < 2; p++) begin
            if (v1[p]) d2[p] <= d1[p];
          end
        end
      end

      assign v_out    = v2;
      assign e_out    = e2;
      assign d_out[0] = d2[0];
      assign d_out[1] = d2[1];
    end else begin : g_lat1
      assign v_out    = v1;
      assign e_out    = e1;
      assign d_out[0] = d1[0];
      assign d_out[1] = d1[1];
    end
  endgenerate

  assign s0.read_data       = d_out[0];
  assign s0.read_data_valid = v_out[0];
  assign s0.resp_err        = e_out[0];
  assign s1.read_data       = d_out[1];
  assign s1.read_data_valid = v_out[1];
  assign s1.resp_err        = e_out[1];
endmodule

// File: tb/tb_avl_dp_ram_v2.sv
// tb/tb_avl_dp_ram_v2.sv - scoreboard bench for two avl_dp_ram_v2 configurations
module tb_avl_dp_ram_v2;
  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  // Config 0: latency 1, port 0 priority, old data; config 1: latency 2, port 1 priority, new data
  avl_dp_ram_v2_if #(.DATA_W(32)) a0 ();
  avl_dp_ram_v2_if #(.DATA_W(32)) a1 ();
  avl_dp_ram_v2_if #(.DATA_W(32)) b0 ();
  avl_dp_ram_v2_if #(.DATA_W(32)) b1 ();

  avl_dp_ram_v2 #(.DATA_W(32), .DEPTH(65536), .RD_LATENCY(1), .WR_PRIORITY(0), .RDW_NEW(0))
    dut_a (.clk(clk), .rest(rest), .s0(a0.slave), .s1(a1.slave));
  avl_dp_ram_v2 #(.DATA_W(32), .DEPTH(65536), .RD_LATENCY(2), .WR_PRIORITY(1), .RDW_NEW(1))
    dut_b (.clk(clk), .rest(rest), .s0(b0.slave), .s1(b1.slave));

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sq [4][$];
  logic [31:0] mdl [2][128];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        rest_seen = 1'b1;
  logic [31:0] hold [4];

  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [3:0]  be [2];
  logic [31:0] wdat [2];

  logic        vv [4];
  logic        ee [4];
  logic        rr [4];
  logic [31:0] dd [4];
  assign vv = '{a0.read_data_valid, a1.read_data_valid, b0.read_data_valid, b1.read_data_valid};
  assign ee = '{a0.resp_err, a1.resp_err, b0.resp_err, b1.resp_err};
  assign rr = '{a0.request_ready, a1.request_ready, b0.request_ready, b1.request_ready};
  assign dd = '{a0.read_data, a1.read_data, b0.read_data, b1.read_data};

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d port%0d cyc=%0d: got %h expected %h", nm, i / 2, i % 2, cyc, got, exp);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return a[31:18] != 14'd0;
  endfunction

  function automatic int wrd(input logic [31:0] a);
    return int'(a[17:2]);
  endfunction

  // Word after this cycle's writes: lower-priority port lanes first, priority port on top
  function automatic logic [31:0] post_word(input int c, input int w);
    logic [31:0] r;
    int          order [2];
    r = mdl[c][w];
    order[0] = (c == 1) ? 0 : 1;
    order[1] = (c == 1) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      int p;
      p = order[k];
      if (wr[p] && !is_oor(ad[p]) && wrd(ad[p]) == w)
        for (int b = 0; b < 4; b++)
          if (be[p][b]) r[8*b +: 8] = wdat[p][8*b +: 8];
    end
    return r;
  endfunction

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; be[p] = '0; wdat[p] = '0;
    end
  endtask

  task automatic set_p(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] e, input logic [31:0] d);
    rd[p] = r; wr[p] = w; ad[p] = a; be[p] = e; wdat[p] = d;
  endtask

  task automatic step(input logic rst);
    int          nxt;
    logic [31:0] post [2];
    exp_t        e;
    rest = rst;
    a0.address = ad[0]; a0.byte_en = be[0]; a0.read = rd[0]; a0.write = wr[0]; a0.write_data = wdat[0];
    a1.address = ad[1]; a1.byte_en = be[1]; a1.read = rd[1]; a1.write = wr[1]; a1.write_data = wdat[1];
    b0.address = ad[0]; b0.byte_en = be[0]; b0.read = rd[0]; b0.write = wr[0]; b0.write_data = wdat[0];
    b1.address = ad[1]; b1.byte_en = be[1]; b1.read = rd[1]; b1.write = wr[1]; b1.write_data = wdat[1];
    nxt = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 4; i++)
        while (sq[i].size() > 0 && sq[i][$].due >= nxt) void'(sq[i].pop_back());
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int p = 0; p < 2; p++) post[p] = is_oor(ad[p]) ? 32'h0 : post_word(c, wrd(ad[p]));
        for (int p = 0; p < 2; p++) begin
          if (rd[p]) begin
            e.due = nxt + c;
            e.err = is_oor(ad[p]);
            if (is_oor(ad[p])) e.data = 32'h0;
            else if (c == 1 && wr[1-p] && !is_oor(ad[1-p]) && wrd(ad[1-p]) == wrd(ad[p])) e.data = post[p];
            else e.data = mdl[c][wrd(ad[p])];
            sq[2*c+p].push_back(e);
          end
        end
        for (int p = 0; p < 2; p++)
          if (wr[p] && !is_oor(ad[p])) mdl[c][wrd(ad[p])] = post[p];
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    idle();
  endtask

  always @(posedge clk) rest_seen <= rest;

  // Monitor: pops the scoreboard whenever a DUT port presents read data
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        chk("request_ready", i, 32'(rr[i]), 32'(!rest));
        if (rest_seen) begin
          chk("reset_valid", i, 32'(vv[i]), 32'd0);
          chk("reset_data", i, dd[i], 32'd0);
          chk("reset_err", i, 32'(ee[i]), 32'd0);
          hold[i] = 32'h0;
        end else if (vv[i]) begin
          if (sq[i].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid cfg%0d port%0d cyc=%0d: got valid 1 expected 0", i / 2, i % 2, cyc);
          end else begin
            e = sq[i].pop_front();
            chk("latency", i, 32'(cyc), 32'(e.due));
            chk("read_data", i, dd[i], e.data);
            chk("resp_err", i, 32'(ee[i]), 32'(e.err));
          end
          hold[i] = dd[i];
        end else begin
          chk("hold_data", i, dd[i], hold[i]);
          if (sq[i].size() > 0 && sq[i][0].due <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_valid cfg%0d port%0d cyc=%0d: got valid 0 expected 1", i / 2, i % 2, cyc);
            void'(sq[i].pop_front());
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) hold[i] = 32'h0;
    idle();
    step(1'b1);
    mon_en = 1'b1;
    step(1'b1);
    step(1'b1);

    for (int i = 0; i < 64; i++) begin
      set_p(0, 1'b0, 1'b1, 32'(8 * i), 4'hF, 32'(2 * i) * 32'h01010101);
      set_p(1, 1'b0, 1'b1, 32'(8 * i + 4), 4'hF, 32'(2 * i + 1) * 32'h01010101);
      step(1'b0);
    end

    set_p(0, 1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF); step(1'b0);
    set_p(1, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);        step(1'b0);

    set_p(0, 1'b0, 1'b1, 32'h40, 4'hF, 32'h11223344);  step(1'b0);
    set_p(0, 1'b0, 1'b1, 32'h40, 4'h3, 32'hAAAAAAAA);
    set_p(1, 1'b0, 1'b1, 32'h40, 4'h6, 32'hBBBBBBBB);  step(1'b0);
    set_p(0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);         step(1'b0);

    set_p(0, 1'b0, 1'b1, 32'h80, 4'hF, 32'h0);         step(1'b0);
    set_p(0, 1'b0, 1'b1, 32'h80, 4'h1, 32'h55);
    set_p(1, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0);         step(1'b0);
    set_p(0, 1'b1, 1'b0, 32'h80, 4'h0, 32'h0);         step(1'b0);

    for (int k = 0; k < 8; k++) begin
      set_p(0, 1'b1, 1'b0, 32'(4 * k), 4'h0, 32'h0);
      step(1'b0);
    end

    set_p(1, 1'b0, 1'b1, 32'h40000, 4'hF, 32'h1234);   step(1'b0);
    set_p(1, 1'b1, 1'b0, 32'h40000, 4'h0, 32'h0);      step(1'b0);
    set_p(0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);          step(1'b0);

    set_p(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         step(1'b0);
    set_p(0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hFFFFFFFF);
    set_p(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);          step(1'b1);
    set_p(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);          step(1'b0);
    step(1'b0);
    step(1'b0);

    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) a = $urandom | 32'h0004_0000;
        else a = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom)};
        set_p(p, 1'($urandom), ($urandom_range(0, 2) == 0), a, 4'($urandom), $urandom);
      end
      step($urandom_range(0, 63) == 0);
    end

    for (int n = 0; n < 5; n++) step(1'b0);
    for (int i = 0; i < 4; i++) chk("drain_empty", i, 32'(sq[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
